// File: rtl/i2c_target_regfile.sv
// I2C target with a small auto-incrementing register file. SCL/SDA are
// oversampled on clk; SDA is open-drain (drives 0 or releases).
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address byte
// IGNORE    | not addressed or master NACKed; wait for START/STOP
// ADDR_ACK  | acking own address
// PTR       | shifting in register pointer
// PTR_ACK   | acking pointer byte
// WDATA     | shifting in write data
// WDATA_ACK | acking write data
// RDATA     | shifting out read data, one bit per SCL fall
// RD_ACK    | sampling master ACK/NACK
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         NUM_REGS = 4,
  parameter logic [7:0] RST_VAL  = 8'h00,
  localparam int        PW       = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  SCL,
  inout  wire                   SDA,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic                  wr_strobe,
  output logic [PW-1:0]         wr_index,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, IGNORE, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK
  } state_t;

  state_t        state, state_n;
  logic          scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n, byte_in, rd_val;
  logic [PW-1:0] ptr, ptr_n;
  logic          drive_low, drive_n, busy_n, rw, rw_n, we;
  logic [7:0]    regs [NUM_REGS];

  // Preset to idle-bus levels so releasing reset never looks like START/STOP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {SCL, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {SDA, sda_s1, sda_s2};
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign byte_in   = {shreg[6:0], sda_s2};
  assign rd_val    = regs[ptr];
  assign SDA       = drive_low ? 1'b0 : 1'bz;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    drive_n   = drive_low;
    busy_n    = busy;
    rw_n      = rw;
    we        = 1'b0;
    if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      drive_n   = 1'b0;
      busy_n    = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      drive_n   = 1'b0;
      busy_n    = 1'b0;
    end else begin
      unique case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              if (state == ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_n = ADDR_ACK;
                  rw_n    = byte_in[0];
                  busy_n  = 1'b1;
                end else begin
                  state_n = IGNORE;
                end
              end else if (state == PTR) begin
                ptr_n   = byte_in[PW-1:0];
                state_n = PTR_ACK;
              end else begin
                we      = 1'b1;
                ptr_n   = ptr + PW'(1);
                state_n = WDATA_ACK;
              end
            end
          end
        end
        // drive_low doubles as the phase flag: first fall asserts ACK, second ends it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!drive_low) begin
              drive_n = 1'b1;
            end else if (state == ADDR_ACK && rw) begin
              state_n   = RDATA;
              shreg_n   = rd_val;
              drive_n   = ~rd_val[7];
              ptr_n     = ptr + PW'(1);
              bit_cnt_n = '0;
            end else begin
              drive_n   = 1'b0;
              bit_cnt_n = '0;
              state_n   = (state == ADDR_ACK) ? PTR : WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              drive_n   = 1'b0;
              bit_cnt_n = '0;
              state_n   = RD_ACK;
            end else begin
              drive_n = ~shreg[6];
              shreg_n = {shreg[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s2) bit_cnt_n = 4'd1;
            else         state_n   = IGNORE;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            state_n   = RDATA;
            shreg_n   = rd_val;
            drive_n   = ~rd_val[7];
            ptr_n     = ptr + PW'(1);
            bit_cnt_n = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      drive_low <= 1'b0;
      busy      <= 1'b0;
      rw        <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      drive_low <= drive_n;
      busy      <= busy_n;
      rw        <= rw_n;
      wr_strobe <= we;
      if (we) wr_index <= ptr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else if (we) begin
      regs[ptr] <= byte_in;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[8*i +: 8] = regs[i];
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, table of write
// transactions, hand-written corner sequences, and randomized traffic vs a register model.
`timescale 1ns/1ps
module tb_i2c_target_regfile;
  localparam int NUM_REGS = 4;
  localparam int Q = 4;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  scl;
  logic                  m_low;
  wire                   sda_bus;
  logic [NUM_REGS*8-1:0] reg_out;
  logic                  wr_strobe;
  logic [1:0]            wr_index;
  logic                  busy;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] strobe_q[$];
  logic [7:0] mregs [NUM_REGS];
  int         mptr;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  i2c_target_regfile #(.DEV_ADDR(7'h42), .NUM_REGS(NUM_REGS), .RST_VAL(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .SCL(scl), .SDA(sda_bus),
    .reg_out(reg_out), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
  );

  always @(negedge clk) if (wr_strobe) strobe_q.push_back(wr_index);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input bit b, output bit s);
    wait_clk(Q); m_low = ~b;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); s = (sda_bus !== 1'b0);
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(Q); m_low = 1'b0;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); m_low = 1'b1;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); m_low = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); m_low = 1'b0;
    wait_clk(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] b);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      b[i] = s;
    end
    bit_xfer(~mack, s);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] p, input int n,
                          input logic [2:0][7:0] d, output bit a_ack, output int n_ack,
                          output bit busy_mid);
    bit k;
    i2c_start();
    write_byte(addr, a_ack);
    wait_clk(Q);
    busy_mid = busy;
    n_ack = 0;
    write_byte(p, k);
    n_ack += int'(k);
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], k);
      n_ack += int'(k);
    end
    i2c_stop();
  endtask

  function automatic logic [31:0] model_flat();
    logic [31:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[8*i +: 8] = mregs[i];
    return f;
  endfunction

  task automatic rnd_write(input logic [7:0] p, input int n, input logic [2:0][7:0] d);
    bit a_ack, bm;
    int n_ack;
    logic [1:0] exp_q[$];
    strobe_q.delete();
    do_write(8'h84, p, n, d, a_ack, n_ack, bm);
    mptr = int'(p) % NUM_REGS;
    for (int i = 0; i < n; i++) begin
      mregs[mptr] = d[i];
      exp_q.push_back(2'(mptr));
      mptr = (mptr + 1) % NUM_REGS;
    end
    check("rw_addr_ack", 32'(a_ack), 32'd1);
    check("rw_data_acks", 32'(n_ack), 32'(n + 1));
    check("rw_busy_mid", 32'(bm), 32'd1);
    check("rw_strobes", 32'(strobe_q.size()), 32'(n));
    for (int i = 0; i < n && i < strobe_q.size(); i++)
      check("rw_wr_index", 32'(strobe_q[i]), 32'(exp_q[i]));
    check("rw_regs", reg_out, model_flat());
    check("rw_busy_end", 32'(busy), 32'd0);
  endtask

  task automatic rnd_read(input bit set_ptr, input logic [7:0] p, input int n);
    bit a;
    logic [7:0] b;
    strobe_q.delete();
    if (set_ptr) begin
      i2c_start();
      write_byte(8'h84, a); check("rd_set_addr_ack", 32'(a), 32'd1);
      write_byte(p, a);     check("rd_set_ptr_ack", 32'(a), 32'd1);
      mptr = int'(p) % NUM_REGS;
    end
    i2c_start();
    write_byte(8'h85, a);
    check("rd_addr_ack", 32'(a), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, b);
      check("rd_data", 32'(b), 32'(mregs[mptr]));
      mptr = (mptr + 1) % NUM_REGS;
    end
    wait_clk(Q);
    check("rd_released", 32'(sda_bus !== 1'b0), 32'd1);
    i2c_stop();
    check("rd_busy_end", 32'(busy), 32'd0);
    check("rd_no_strobe", 32'(strobe_q.size()), 32'd0);
  endtask

  task automatic rnd_bad(input logic [2:0][7:0] d);
    logic [7:0] addr;
    bit a_ack, bm;
    int n_ack;
    do addr = 8'($urandom); while (addr[7:1] == 7'h42);
    strobe_q.delete();
    do_write(addr, 8'($urandom), 1, d, a_ack, n_ack, bm);
    check("bad_addr_ack", 32'(a_ack), 32'd0);
    check("bad_data_acks", 32'(n_ack), 32'd0);
    check("bad_busy", 32'(bm), 32'd0);
    check("bad_strobes", 32'(strobe_q.size()), 32'd0);
    check("bad_regs", reg_out, model_flat());
  endtask

  typedef struct {
    logic [7:0]      addr;
    logic [7:0]      ptr;
    int              n;
    logic [2:0][7:0] d;
    bit              exp_aack;
    int              exp_nack;
    logic [31:0]     exp_regs;
    int              exp_strobes;
    logic [1:0]      exp_last;
  } wvec_t;

  wvec_t tbl [6];

  initial begin
    bit a, bm, s;
    int n_ack;
    logic [7:0] b;

    tbl[0] = '{8'h84, 8'h01, 1, 24'h0000A5, 1'b1, 2, 32'h0000A500, 1, 2'd1};
    tbl[1] = '{8'h84, 8'h03, 2, 24'h002211, 1'b1, 3, 32'h1100A522, 2, 2'd0};
    tbl[2] = '{8'h90, 8'h02, 1, 24'h000077, 1'b0, 0, 32'h1100A522, 0, 2'd0};
    tbl[3] = '{8'h84, 8'h06, 1, 24'h00005C, 1'b1, 2, 32'h115CA522, 1, 2'd2};
    tbl[4] = '{8'h86, 8'h01, 2, 24'h00FFEE, 1'b0, 0, 32'h115CA522, 0, 2'd0};
    tbl[5] = '{8'h84, 8'h0E, 3, 24'hCCBBAA, 1'b1, 4, 32'hBBAAA5CC, 3, 2'd0};

    reset_n = 1'b0; scl = 1'b1; m_low = 1'b0;
    wait_clk(4);
    check("rst_regs", reg_out, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobe", 32'(wr_strobe), 32'd0);
    check("rst_sda", 32'(sda_bus !== 1'b0), 32'd1);
    reset_n = 1'b1;
    wait_clk(8);

    for (int v = 0; v < 6; v++) begin
      strobe_q.delete();
      do_write(tbl[v].addr, tbl[v].ptr, tbl[v].n, tbl[v].d, a, n_ack, bm);
      check($sformatf("tbl%0d_addr_ack", v), 32'(a), 32'(tbl[v].exp_aack));
      check($sformatf("tbl%0d_busy_mid", v), 32'(bm), 32'(tbl[v].exp_aack));
      check($sformatf("tbl%0d_data_acks", v), 32'(n_ack), 32'(tbl[v].exp_nack));
      check($sformatf("tbl%0d_regs", v), reg_out, tbl[v].exp_regs);
      check($sformatf("tbl%0d_strobes", v), 32'(strobe_q.size()), 32'(tbl[v].exp_strobes));
      if (strobe_q.size() > 0)
        check($sformatf("tbl%0d_last_index", v), 32'(strobe_q[$]), 32'(tbl[v].exp_last));
      check($sformatf("tbl%0d_busy_end", v), 32'(busy), 32'd0);
    end

    // Pointer write, repeated START, read two bytes (ACK then NACK).
    i2c_start();
    write_byte(8'h84, a); check("seq_rd_addr_w_ack", 32'(a), 32'd1);
    write_byte(8'h01, a); check("seq_rd_ptr_ack", 32'(a), 32'd1);
    i2c_start();
    write_byte(8'h85, a); check("seq_rd_addr_r_ack", 32'(a), 32'd1);
    check("seq_rd_busy", 32'(busy), 32'd1);
    read_byte(1'b1, b); check("seq_rd_byte0", 32'(b), 32'hA5);
    read_byte(1'b0, b); check("seq_rd_byte1", 32'(b), 32'hAA);
    wait_clk(Q);
    check("seq_rd_released", 32'(sda_bus !== 1'b0), 32'd1);
    i2c_stop();
    check("seq_rd_busy_end", 32'(busy), 32'd0);

    // STOP after four data bits: nothing committed.
    strobe_q.delete();
    i2c_start();
    write_byte(8'h84, a); check("seq_stop_addr_ack", 32'(a), 32'd1);
    write_byte(8'h00, a); check("seq_stop_ptr_ack", 32'(a), 32'd1);
    bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b0, s);
    i2c_stop();
    check("seq_stop_strobes", 32'(strobe_q.size()), 32'd0);
    check("seq_stop_regs", reg_out, 32'hBBAAA5CC);
    check("seq_stop_busy", 32'(busy), 32'd0);

    // Reset mid data byte, then a normal write must succeed.
    strobe_q.delete();
    i2c_start();
    write_byte(8'h84, a); check("seq_rst_addr_ack", 32'(a), 32'd1);
    write_byte(8'h01, a); check("seq_rst_ptr_ack", 32'(a), 32'd1);
    bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s);
    wait_clk(Q); m_low = 1'b0;
    reset_n = 1'b0;
    wait_clk(2);
    check("seq_rst_sda", 32'(sda_bus !== 1'b0), 32'd1);
    check("seq_rst_regs", reg_out, 32'h0);
    check("seq_rst_busy", 32'(busy), 32'd0);
    scl = 1'b1;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(8);
    check("seq_rst_strobes", 32'(strobe_q.size()), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
    mptr = 0;
    rnd_write(8'h02, 1, 24'h00003C);

    for (int t = 0; t < 16; t++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      if (kind == 0)      rnd_write(8'($urandom), int'($urandom_range(1, 3)), 24'($urandom));
      else if (kind == 1) rnd_read(1'($urandom), 8'($urandom), int'($urandom_range(1, 3)));
      else                rnd_bad(24'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
